// File: rtl/alu_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// alu_issue_pkg
// Shared definitions for the FP ALU issue/capture stage.
//   - opcode encodings as presented on the ALU 'o' input
//   - control FSM state encoding
//   - IEEE-754 single-precision field geometry
//   - select_result(): picks the ALU output that belongs to an opcode
// -----------------------------------------------------------------------------
package alu_issue_pkg;

    // Opcodes. Any opcode with the MSB set is a compare.
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_MUL     = 3'b010;
    localparam logic [2:0] OP_DIV     = 3'b011;
    localparam int         OP_CMP_MSB = 2;

    // Control states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_e;

    // IEEE-754 single-precision fields.
    localparam int         EXP_W    = 8;
    localparam int         MAN_W    = 23;
    localparam logic [7:0] EXP_ALL1 = 8'hFF;

    // Result multiplexer. A compare returns the comparator bit in the LSB;
    // add and sub share one ALU output.
    function automatic logic [31:0] select_result(
        input logic [2:0]  op,
        input logic [31:0] add_sub,
        input logic [31:0] mul,
        input logic [31:0] div,
        input logic        z
    );
        logic [31:0] res;
        if (op[OP_CMP_MSB]) begin
            res = {31'b0, z};
        end else begin
            case (op[1:0])
                2'b00, 2'b01: res = add_sub;
                2'b10:        res = mul;
                default:      res = div;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl_if
// Bundles the three buses around the issue stage:
//   request  : req_valid/req_ready, req_a, req_b, req_op
//   ALU side : alu_a/alu_b/alu_o to the ALU, alu_add_sub/alu_mul/alu_div/alu_z back
//   response : resp_valid/resp_ready, resp_data, resp_nan/resp_inf/resp_zero
// Modports:
//   slave  - the issue stage itself
//   master - the surroundings (operand source, ALU, result consumer)
// -----------------------------------------------------------------------------
interface alu_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_o;
    logic [31:0] alu_add_sub;
    logic [31:0] alu_mul;
    logic [31:0] alu_div;
    logic        alu_z;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_nan;
    logic        resp_inf;
    logic        resp_zero;

    modport slave (
        input  req_valid, req_a, req_b, req_op,
        output req_ready,
        output alu_a, alu_b, alu_o,
        input  alu_add_sub, alu_mul, alu_div, alu_z,
        output resp_valid, resp_data, resp_nan, resp_inf, resp_zero,
        input  resp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_op,
        input  req_ready,
        input  alu_a, alu_b, alu_o,
        output alu_add_sub, alu_mul, alu_div, alu_z,
        input  resp_valid, resp_data, resp_nan, resp_inf, resp_zero,
        output resp_ready
    );

endinterface

// File: rtl/alu_issue_ctrl_fp_classify.sv
// -----------------------------------------------------------------------------
// fp_classify
// Combinational IEEE-754 single-precision classifier.
// Ports:
//   value_i [31:0] : value to classify
//   nan_o          : exponent all ones, mantissa non-zero
//   inf_o          : exponent all ones, mantissa zero (either sign)
//   zero_o         : exponent zero, mantissa zero (either sign)
// -----------------------------------------------------------------------------
module fp_classify
    import alu_issue_pkg::*;
(
    input  logic [31:0] value_i,
    output logic        nan_o,
    output logic        inf_o,
    output logic        zero_o
);

    logic [EXP_W-1:0] exp_field;
    logic [MAN_W-1:0] man_field;
    logic             man_nonzero;
    logic             unused_sign;

    assign exp_field   = value_i[MAN_W +: EXP_W];
    assign man_field   = value_i[MAN_W-1:0];
    assign man_nonzero = |man_field;
    // Classification is sign-independent.
    assign unused_sign = value_i[31];

    assign nan_o  = (exp_field == EXP_ALL1) &&  man_nonzero;
    assign inf_o  = (exp_field == EXP_ALL1) && !man_nonzero;
    assign zero_o = (exp_field == '0)       && !man_nonzero;

endmodule

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
// Issue/capture stage for a purely combinational FP ALU. Accepts one request,
// holds the operands on the ALU inputs for SETTLE_CYCLES clocks so the deep
// paths (notably the divider) settle, then registers the opcode-selected
// result with NaN/inf/zero flags and offers it on a valid/ready handshake.
// Parameters:
//   SETTLE_CYCLES : clocks from accept edge to capture edge (1..255)
//   CNT_W         : width of the completed-operation counter
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : request, ALU and response buses
//   done_count    : completed response handshakes, wraps
// -----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    alu_issue_ctrl_if.slave   bus,
    output logic [CNT_W-1:0]  done_count
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("alu_issue_ctrl: SETTLE_CYCLES must be in 1..255");
    end

    // The counter is loaded with SETTLE_CYCLES-1 at accept and captures when
    // it reaches zero, so capture lands exactly SETTLE_CYCLES edges later.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_e           state_q,     state_d;
    logic [7:0]       cnt_q,       cnt_d;
    logic [31:0]      alu_a_q,     alu_a_d;
    logic [31:0]      alu_b_q,     alu_b_d;
    logic [2:0]       alu_o_q,     alu_o_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic             resp_nan_q,  resp_nan_d;
    logic             resp_inf_q,  resp_inf_d;
    logic             resp_zero_q, resp_zero_d;
    logic [CNT_W-1:0] done_q,      done_d;

    logic [31:0]      sel_value;
    logic             sel_nan;
    logic             sel_inf;
    logic             sel_zero;
    logic             is_cmp;

    // Result selection runs off the registered opcode, i.e. the one the ALU
    // is actually computing.
    assign sel_value = select_result(alu_o_q, bus.alu_add_sub, bus.alu_mul,
                                     bus.alu_div, bus.alu_z);
    assign is_cmp    = alu_o_q[OP_CMP_MSB];

    fp_classify u_classify (
        .value_i (sel_value),
        .nan_o   (sel_nan),
        .inf_o   (sel_inf),
        .zero_o  (sel_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_o_q     <= OP_ADD;
            resp_data_q <= '0;
            resp_nan_q  <= 1'b0;
            resp_inf_q  <= 1'b0;
            resp_zero_q <= 1'b0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_o_q     <= alu_o_d;
            resp_data_q <= resp_data_d;
            resp_nan_q  <= resp_nan_d;
            resp_inf_q  <= resp_inf_d;
            resp_zero_q <= resp_zero_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_o_d     = alu_o_q;
        resp_data_d = resp_data_q;
        resp_nan_d  = resp_nan_q;
        resp_inf_d  = resp_inf_q;
        resp_zero_d = resp_zero_q;
        done_d      = done_q;

        case (state_q)
            IDLE: begin
                // req_ready is high throughout IDLE, so valid alone accepts.
                if (bus.req_valid) begin
                    alu_a_d = bus.req_a;
                    alu_b_d = bus.req_b;
                    alu_o_d = bus.req_op;
                    cnt_d   = SETTLE_LOAD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    resp_data_d = sel_value;
                    resp_nan_d  = !is_cmp && sel_nan;
                    resp_inf_d  = !is_cmp && sel_inf;
                    resp_zero_d = !is_cmp && sel_zero;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    done_d  = done_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_o      = alu_o_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_nan   = resp_nan_q;
    assign bus.resp_inf   = resp_inf_q;
    assign bus.resp_zero  = resp_zero_q;
    assign done_count     = done_q;

endmodule
